// File: rtl/rv_pkg.sv
// rv_pkg: shared RISC-V fetch types and default constants.
package rv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DEF_RESET_PC = 32'd0;
    localparam logic [XLEN-1:0] DEF_PC_STEP = 32'd4;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} fetch_state_e;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: next-PC select (redirect > stall > increment) with 33-bit range check.
module pc_next_sel
    import rv_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter logic [XLEN-1:0] PC_STEP = DEF_PC_STEP
)(
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_stall,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic [XLEN-1:0] o_next_pc,
    output logic            o_out_of_range
);
    // One extra bit so an increment wrapping past 2^32 still reads as out of range.
    logic [XLEN:0] w_next;
    assign w_next = i_redirect_valid ? {1'b0, i_redirect_pc} :
                    i_stall          ? {1'b0, i_pc} :
                                       {1'b0, i_pc} + {1'b0, PC_STEP};
    assign o_next_pc = w_next[XLEN-1:0];
    assign o_out_of_range = w_next >= (XLEN+1)'(DEPTH);
endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: boot-loads the instruction memory, then sequences the fetch PC
// until it leaves the memory range.
module imem_fetch_ctrl
    import rv_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [XLEN-1:0] PC_STEP = DEF_PC_STEP,
    localparam int IDX_W = $clog2(DEPTH)
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [31:0]      load_data,
    input  logic             load_last,
    output logic             load_ready,
    input  logic             start,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_waddr,
    output logic [31:0]      mem_wdata,
    output logic [IDX_W-1:0] mem_raddr,
    input  logic [31:0]      mem_rdata,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      pc,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic             halted,
    output logic             load_err
);
    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc, r_load_ptr;
    logic            r_load_ready, r_instr_valid, r_halted, r_load_err;
    logic [XLEN-1:0] w_next_pc;
    logic            w_pc_oob, w_accept, w_load_full;

    pc_next_sel #(.DEPTH(DEPTH), .PC_STEP(PC_STEP)) u_pc_next_sel (
        .i_pc(r_pc),
        .i_stall(stall),
        .i_redirect_valid(redirect_valid),
        .i_redirect_pc(redirect_pc),
        .o_next_pc(w_next_pc),
        .o_out_of_range(w_pc_oob)
    );

    // load_ready is high exactly in LOAD, so it doubles as the write-port ownership flag.
    assign w_accept = r_load_ready && load_valid;
    assign w_load_full = ({1'b0, r_load_ptr} + {1'b0, PC_STEP}) > (XLEN+1)'(DEPTH - 1);
    assign mem_we = w_accept;
    assign mem_waddr = r_load_ptr[IDX_W-1:0];
    assign mem_wdata = load_data;
    assign mem_raddr = r_pc[IDX_W-1:0];
    assign instr = mem_rdata;
    assign pc = r_pc;
    assign load_ready = r_load_ready;
    assign instr_valid = r_instr_valid;
    assign halted = r_halted;
    assign load_err = r_load_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_pc <= RESET_PC;
            r_load_ptr <= RESET_PC;
            r_load_ready <= 1'b0;
            r_instr_valid <= 1'b0;
            r_halted <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load_valid) begin
                        r_state <= LOAD;
                        r_load_ready <= 1'b1;
                    end else if (start) begin
                        r_state <= RUN;
                        r_instr_valid <= 1'b1;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        r_load_ptr <= r_load_ptr + PC_STEP;
                        if (load_last) begin
                            r_state <= RUN;
                            r_load_ready <= 1'b0;
                            r_instr_valid <= 1'b1;
                            r_pc <= RESET_PC;
                        end else if (w_load_full) begin
                            r_state <= HALT;
                            r_load_ready <= 1'b0;
                            r_halted <= 1'b1;
                            r_load_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_pc_oob) begin
                        r_state <= HALT;
                        r_instr_valid <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_pc <= w_next_pc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed and random fetch/load sequences against a rule-level model.
module tb_imem_fetch_ctrl;
    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset, load_valid, load_last, start, stall, redirect_valid;
    logic [31:0] load_data, redirect_pc, pc, instr, mem_wdata, mem_rdata;
    logic [4:0]  mem_waddr, mem_raddr;
    logic        load_ready, mem_we, instr_valid, halted, load_err;

    logic [31:0] mem [DEPTH];
    logic [31:0] exp_img [DEPTH];
    int          ncmp = 0, nfail = 0;
    logic [31:0] m_pc;
    bit          m_run, m_halt;

    imem_fetch_ctrl dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
        .start(start),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .pc(pc), .instr(instr), .instr_valid(instr_valid), .halted(halted), .load_err(load_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;
    assign mem_rdata = mem[mem_raddr];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        reset = 1'b1; load_valid = 1'b0; load_last = 1'b0; start = 1'b0;
        stall = 1'b0; redirect_valid = 1'b0;
        tick;
        reset = 1'b0;
        m_run = 1'b0; m_halt = 1'b0; m_pc = 32'd0;
    endtask

    task automatic reset_checks;
        chkb("rst_load_ready", load_ready, 1'b0);
        chkb("rst_mem_we", mem_we, 1'b0);
        chkb("rst_instr_valid", instr_valid, 1'b0);
        chkb("rst_halted", halted, 1'b0);
        chkb("rst_load_err", load_err, 1'b0);
        chk("rst_pc", pc, 32'd0);
    endtask

    task automatic start_run;
        start = 1'b1;
        tick;
        start = 1'b0;
        m_run = 1'b1; m_halt = 1'b0; m_pc = 32'd0;
    endtask

    task automatic load_word(input logic [31:0] d, input bit last, input int idx);
        load_valid = 1'b1; load_data = d; load_last = last;
        #1;
        chkb("load_ready", load_ready, 1'b1);
        chkb("load_we", mem_we, 1'b1);
        chk("load_waddr", 32'(mem_waddr), 32'(idx * 4));
        chk("load_wdata", mem_wdata, d);
        exp_img[idx * 4] = d;
        tick;
    endtask

    // Model: next PC from the priority rules; anything at or beyond DEPTH halts with pc held.
    task automatic run_cycle(input bit st, input bit rv, input logic [31:0] rpc);
        longint nx;
        stall = st; redirect_valid = rv; redirect_pc = rpc;
        #1;
        chk("pc", pc, m_pc);
        chkb("instr_valid", instr_valid, m_run);
        chkb("halted", halted, m_halt);
        chkb("run_mem_we", mem_we, 1'b0);
        if (m_run) chk("instr", instr, exp_img[m_pc[4:0]]);
        tick;
        if (m_run) begin
            nx = rv ? longint'(rpc) : st ? longint'(m_pc) : longint'(m_pc) + 4;
            if (nx >= DEPTH) begin
                m_run = 1'b0; m_halt = 1'b1;
            end else m_pc = nx[31:0];
        end
        stall = 1'b0; redirect_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        bit st, rv;
        logic [31:0] rpc;
        int r;
        load_data = 32'd0; redirect_pc = 32'd0;
        do_reset;
        do_reset;
        reset_checks;

        // Load 7 words, then run off the end of memory
        w = $urandom;
        load_valid = 1'b1; load_data = w; load_last = 1'b0;
        #1;
        chkb("idle_no_we", mem_we, 1'b0);
        tick;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) w = $urandom;
            load_word(w, i == 6, i);
        end
        load_valid = 1'b0; load_last = 1'b0;
        m_run = 1'b1; m_pc = 32'd0;
        for (int k = 0; k < 10; k++) run_cycle(1'b0, 1'b0, 32'd0);
        chk("halt_pc", pc, 32'd28);

        // Stall, redirect under stall, out-of-range redirect
        do_reset;
        start_run;
        run_cycle(1'b0, 1'b0, 32'd0);
        run_cycle(1'b0, 1'b0, 32'd0);
        for (int k = 0; k < 3; k++) run_cycle(1'b1, 1'b0, 32'd0);
        run_cycle(1'b1, 1'b1, 32'd20);
        run_cycle(1'b0, 1'b0, 32'd0);
        run_cycle(1'b0, 1'b1, 32'd40);
        run_cycle(1'b0, 1'b0, 32'd0);
        chk("redir_oob_pc", pc, 32'd24);

        // Image overflow: 8 words fill memory, the 9th is refused
        do_reset;
        load_valid = 1'b1; load_data = $urandom; load_last = 1'b0;
        tick;
        for (int i = 0; i < 8; i++) load_word($urandom, 1'b0, i);
        load_valid = 1'b1; load_data = $urandom; load_last = 1'b0;
        #1;
        chkb("ovf_load_ready", load_ready, 1'b0);
        chkb("ovf_mem_we", mem_we, 1'b0);
        chkb("ovf_load_err", load_err, 1'b1);
        chkb("ovf_halted", halted, 1'b1);
        chkb("ovf_instr_valid", instr_valid, 1'b0);
        tick;
        load_valid = 1'b0;
        m_halt = 1'b1; m_run = 1'b0; m_pc = 32'd0;
        run_cycle(1'b0, 1'b1, 32'd4);

        // Reset mid-load keeps the partial image
        do_reset;
        load_valid = 1'b1; load_data = $urandom; load_last = 1'b0;
        tick;
        for (int i = 0; i < 3; i++) load_word($urandom, 1'b0, i);
        do_reset;
        reset_checks;
        start_run;
        for (int k = 0; k < 3; k++) run_cycle(1'b0, 1'b0, 32'd0);

        // start and load_valid together: load wins, load pointer back at 0
        do_reset;
        w = $urandom;
        load_valid = 1'b1; start = 1'b1; load_data = w; load_last = 1'b0;
        #1;
        chkb("both_no_we", mem_we, 1'b0);
        tick;
        start = 1'b0;
        chkb("both_instr_valid", instr_valid, 1'b0);
        load_word(w, 1'b1, 0);
        load_valid = 1'b0; load_last = 1'b0;
        m_run = 1'b1; m_pc = 32'd0;
        run_cycle(1'b0, 1'b0, 32'd0);

        // Random stall/redirect traffic
        for (int n = 0; n < 300; n++) begin
            if (m_halt) begin
                do_reset;
                start_run;
            end
            r = $urandom_range(0, 9);
            st = (r < 3);
            rv = (r >= 7);
            if ($urandom_range(0, 7) == 0)
                rpc = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC : 32'(32 + 4 * $urandom_range(0, 7));
            else
                rpc = 32'(4 * $urandom_range(0, 7));
            run_cycle(st, rv, rpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
